aes128_enc_iter: RTL

//  Iterative AES-128 encryption engine with on-the-fly key expansion and a valid/ready stream interface.
//  - UNROLL = number of aes_round instances chained combinationally per clock; trades area against latency.
//  - Sits between the block-request source and the ciphertext sink as the first full cipher core built on aes_round and aes_sbox.

---
 rtl/aes128_enc_iter_pkg.sv | 53 +++++
 rtl/aes128_enc_iter_if.sv | 22 ++
 rtl/aes_key_step.sv | 29 ++
 rtl/aes_round.sv | 35 +++
 rtl/aes_sbox.sv | 11 +
 rtl/aes128_enc_iter.sv | 131 +++++++++++++
 6 files changed

// File: rtl/aes128_enc_iter_pkg.sv
// Shared AES-128 definitions for the iterative encryption engine:
// round count, Rcon table, S-box table, GF(2^8) helpers and FSM state type.
package aes128_enc_iter_pkg;

   localparam int AES_NR = 10;

   localparam logic [7:0] AES_RCON [0:9] = '{
      8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
   };

   // Entry n of the forward S-box sits at bits [2047-8n -: 8].
   localparam logic [2047:0] AES_SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } aes_state_e;

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [31:0] mix_column(input logic [31:0] col);
      logic [7:0] a0, a1, a2, a3;
      a0 = col[31:24];
      a1 = col[23:16];
      a2 = col[15:8];
      a3 = col[7:0];
      return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
              a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
              a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
              xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
   endfunction

endpackage

// File: rtl/aes128_enc_iter_if.sv
// Block-in / ciphertext-out stream bundle of the iterative AES-128 engine.
// master = block source + ciphertext sink, slave = the engine.
interface aes128_enc_iter_if;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] in_block;
   logic [127:0] in_key;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] out_block;
   logic         busy;

   modport master (
      output in_valid, in_block, in_key, out_ready,
      input  in_ready, out_valid, out_block, busy
   );

   modport slave (
      input  in_valid, in_block, in_key, out_ready,
      output in_ready, out_valid, out_block, busy
   );
endinterface

// File: rtl/aes_key_step.sv
// One AES-128 key-schedule step: next round key from the previous one and its Rcon.
module aes_key_step (
   input  logic [127:0] key_in,
   input  logic [7:0]   rcon_in,
   output logic [127:0] key_out
);

   logic [31:0] rot_word;
   logic [31:0] sub_word;
   logic [31:0] t_word;
   logic [31:0] w0, w1, w2, w3;

   assign rot_word = {key_in[23:0], key_in[31:24]};

   for (genvar i = 0; i < 4; i++) begin : g_sbox
      aes_sbox u_sbox (
         .in_byte  (rot_word[31-8*i -: 8]),
         .out_byte (sub_word[31-8*i -: 8])
      );
   end

   assign t_word  = sub_word ^ {rcon_in, 24'h0};
   assign w0      = key_in[127:96] ^ t_word;
   assign w1      = key_in[95:64]  ^ w0;
   assign w2      = key_in[63:32]  ^ w1;
   assign w3      = key_in[31:0]   ^ w2;
   assign key_out = {w0, w1, w2, w3};

endmodule

// File: rtl/aes_round.sv
// One AES encryption round; final_round skips MixColumns.
module aes_round
   import aes128_enc_iter_pkg::*;
(
   input  logic [127:0] state_in,
   input  logic [127:0] round_key,
   input  logic         final_round,
   output logic [127:0] state_out
);

   logic [127:0] sb;
   logic [127:0] sr;
   logic [127:0] mc;

   for (genvar i = 0; i < 16; i++) begin : g_sbox
      aes_sbox u_sbox (
         .in_byte  (state_in[127-8*i -: 8]),
         .out_byte (sb[127-8*i -: 8])
      );
   end

   // Byte i is row i%4, column i/4; row r rotates left by r columns.
   for (genvar r = 0; r < 4; r++) begin : g_row
      for (genvar c = 0; c < 4; c++) begin : g_col
         assign sr[127-8*(r+4*c) -: 8] = sb[127-8*(r+4*((c+r)%4)) -: 8];
      end
   end

   for (genvar c = 0; c < 4; c++) begin : g_mix
      assign mc[127-32*c -: 32] = mix_column(sr[127-32*c -: 32]);
   end

   assign state_out = (final_round ? sr : mc) ^ round_key;

endmodule

// File: rtl/aes_sbox.sv
// Forward AES S-box as a table lookup.
module aes_sbox
   import aes128_enc_iter_pkg::*;
(
   input  logic [7:0] in_byte,
   output logic [7:0] out_byte
);

   assign out_byte = AES_SBOX[11'(2047 - 8 * int'(in_byte)) -: 8];

endmodule

// File: rtl/aes128_enc_iter.sv
// Iterative AES-128 encryption core: UNROLL rounds per clock with on-the-fly
// key expansion, one block in flight, valid/ready on both sides.
//
// state | meaning
// IDLE  | no block held, ready for a new one
// RUN   | applying UNROLL rounds per cycle
// DONE  | ciphertext presented until the sink takes it
module aes128_enc_iter
   import aes128_enc_iter_pkg::*;
#(
   parameter int UNROLL = 1
) (
   input  logic              clk,
   input  logic              rst,
   aes128_enc_iter_if.slave  stream
);

   if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 5 || UNROLL == 10)) begin : g_bad_unroll
      $error("aes128_enc_iter: UNROLL must be 1, 2, 5 or 10");
   end

   aes_state_e   state;
   logic [127:0] st_q;
   logic [127:0] key_q;
   logic [7:0]   rcon_q;
   logic [3:0]   round_ctr;
   logic         out_valid_q;
   logic [127:0] out_block_q;
   logic         busy_q;

   logic         in_ready_c;
   logic         accept;
   logic         done_step;

   logic [127:0] st_c  [UNROLL+1];
   logic [127:0] key_c [UNROLL+1];
   logic [7:0]   rc_c  [UNROLL+1];

   assign st_c[0]  = st_q;
   assign key_c[0] = key_q;
   assign rc_c[0]  = rcon_q;

   for (genvar u = 0; u < UNROLL; u++) begin : g_round
      aes_key_step u_key_step (
         .key_in  (key_c[u]),
         .rcon_in (rc_c[u]),
         .key_out (key_c[u+1])
      );

      aes_round u_round (
         .state_in    (st_c[u]),
         .round_key   (key_c[u+1]),
         .final_round (round_ctr + 4'(u) == 4'(AES_NR)),
         .state_out   (st_c[u+1])
      );

      assign rc_c[u+1] = xtime(rc_c[u]);
   end

   assign in_ready_c = !rst && ((state == IDLE) || ((state == DONE) && stream.out_ready));
   assign accept     = stream.in_valid && in_ready_c;
   assign done_step  = (round_ctr + 4'(UNROLL - 1)) == 4'(AES_NR);

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         st_q        <= '0;
         key_q       <= '0;
         rcon_q      <= 8'h01;
         round_ctr   <= 4'd0;
         out_valid_q <= 1'b0;
         out_block_q <= '0;
         busy_q      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  st_q      <= stream.in_block ^ stream.in_key;
                  key_q     <= stream.in_key;
                  rcon_q    <= 8'h01;
                  round_ctr <= 4'd1;
                  busy_q    <= 1'b1;
                  state     <= RUN;
               end
            end
            RUN: begin
               st_q      <= st_c[UNROLL];
               key_q     <= key_c[UNROLL];
               rcon_q    <= rc_c[UNROLL];
               round_ctr <= round_ctr + 4'(UNROLL);
               if (done_step) begin
                  out_block_q <= st_c[UNROLL];
                  out_valid_q <= 1'b1;
                  busy_q      <= 1'b0;
                  state       <= DONE;
               end
            end
            DONE: begin
               // in_ready in DONE implies out_ready, so an accept here is also the output transfer.
               if (stream.out_ready) begin
                  out_valid_q <= 1'b0;
                  if (accept) begin
                     st_q      <= stream.in_block ^ stream.in_key;
                     key_q     <= stream.in_key;
                     rcon_q    <= 8'h01;
                     round_ctr <= 4'd1;
                     busy_q    <= 1'b1;
                     state     <= RUN;
                  end else begin
                     state <= IDLE;
                  end
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign stream.in_ready  = in_ready_c;
   assign stream.out_valid = out_valid_q;
   assign stream.out_block = out_block_q;
   assign stream.busy      = busy_q;

   a_round_ctr_range: assert property (@(posedge clk) disable iff (rst) round_ctr <= 4'd11);

   a_rcon_tracks_round: assert property (@(posedge clk) disable iff (rst)
      (state == RUN) |-> (rcon_q == AES_RCON[round_ctr - 4'd1]));

endmodule
